// File: rtl/bpsk_chip_modulator.sv
// BPSK chip modulator: multiplies the sine carrier by the spread chip stream.
// Chips are queued in a small FIFO. The active chip changes only on a carrier
// phase-0 sample (sine_sync). Chip 0 passes the sample through; chip 1 negates it.
module bpsk_chip_modulator #(
    parameter int SAMPLES_PER_CHIP = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chip_in,
    input  logic              chip_valid,
    output logic              chip_ready,
    input  logic signed [7:0] sine_in,
    input  logic              sine_sync,
    output logic signed [7:0] mod_out,
    output logic              mod_valid,
    output logic              underflow,
    output logic              sync_err
);

    localparam int CW = $clog2(SAMPLES_PER_CHIP);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    // chip FIFO
    logic [FIFO_DEPTH-1:0] fifo_mem;
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           count;
    logic                  full, empty, push, pop;

    // FSM and chip tracking
    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  cur_chip, chip_nxt;
    logic                  run_sample, uf_nxt, serr_set;

    // datapath
    logic signed [8:0]     neg9;
    logic signed [7:0]     neg_sat, mod_nxt;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign chip_ready = !full;
    assign push       = chip_valid && chip_ready;

    // FIFO storage and pointers. Pop only sees the registered count, so a chip
    // written this cycle cannot be consumed until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_mem <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= chip_in;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Next state, chip pop, and boundary or misalignment detection.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CW'(1);
        chip_nxt   = cur_chip;
        pop        = 1'b0;
        run_sample = 1'b0;
        uf_nxt     = 1'b0;
        serr_set   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (sine_sync && !empty) begin
                    pop        = 1'b1;
                    chip_nxt   = fifo_mem[rd_ptr];
                    cnt_nxt    = CW'(1);
                    state_nxt  = RUN;
                    run_sample = 1'b1;
                end
            end
            RUN: begin
                run_sample = 1'b1;
                if (sine_sync) begin
                    // Off-period sync is still treated as a boundary, which realigns the counter.
                    if (cnt != '0)
                        serr_set = 1'b1;
                    if (!empty) begin
                        pop      = 1'b1;
                        chip_nxt = fifo_mem[rd_ptr];
                        cnt_nxt  = CW'(1);
                    end else begin
                        state_nxt  = IDLE;
                        run_sample = 1'b0;
                        uf_nxt     = 1'b1;
                        cnt_nxt    = '0;
                    end
                end else if (cnt == '0) begin
                    // The expected boundary did not arrive. Keep the current chip.
                    serr_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Negate at 9 bits. The only value that can overflow is -(-128).
    assign neg9    = -$signed({sine_in[7], sine_in});
    assign neg_sat = (neg9 == 9'sd128) ? 8'sd127 : neg9[7:0];

    // Output sample. A chip popped this cycle already applies to this sample.
    always_comb begin
        mod_nxt = '0;
        if (run_sample)
            mod_nxt = chip_nxt ? neg_sat : sine_in;
    end

    // State, chip, counter, and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_chip  <= 1'b0;
            mod_out   <= '0;
            mod_valid <= 1'b0;
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_chip  <= chip_nxt;
            mod_out   <= mod_nxt;
            mod_valid <= run_sample;
            underflow <= uf_nxt;
            sync_err  <= sync_err | serr_set;
        end
    end

endmodule

// File: tb/tb_bpsk_chip_modulator.sv
// Directed bench for bpsk_chip_modulator. Inputs change 1ns after a rising
// edge. Outputs are sampled 1ns after the next rising edge.
module tb_bpsk_chip_modulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              chip_in, chip_valid, chip_ready;
    logic signed [7:0] sine_in;
    logic              sine_sync;
    logic signed [7:0] mod_out;
    logic              mod_valid, underflow, sync_err;

    int vectors     = 0;
    int miscompares = 0;

    bpsk_chip_modulator #(.SAMPLES_PER_CHIP(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .chip_in    (chip_in),
        .chip_valid (chip_valid),
        .chip_ready (chip_ready),
        .sine_in    (sine_in),
        .sine_sync  (sine_sync),
        .mod_out    (mod_out),
        .mod_valid  (mod_valid),
        .underflow  (underflow),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Expected BPSK output for one sample.
    function automatic int expm(input logic c, input int s);
        if (!c) return s;
        if (s == -128) return 127;
        return -s;
    endfunction

    // Default carrier sample for position k within a chip.
    function automatic int samp(input int k);
        return k * 13 - 100;
    endfunction

    // Apply one clock of inputs and step to the sampling point after the edge.
    task automatic cyc(input logic v, input logic c, input int s, input logic sy);
        chip_valid = v;
        chip_in    = c;
        sine_in    = 8'(s);
        sine_sync  = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Run one full chip period, starting with sine_sync, and check every output sample.
    task automatic run_chip(input logic c, input int s0, input int s1, input logic chk_ready);
        for (int k = 0; k < 16; k++) begin
            int s;
            s = (k == 0) ? s0 : (k == 1) ? s1 : samp(k);
            cyc(0, 0, s, k == 0);
            vectors++;
            if (mod_valid !== 1'b1 || mod_out !== 8'(expm(c, s))) begin
                miscompares++;
                $display("FAIL run_chip[%0d] chip=%0d in=%0d: got valid=%0d out=%0d, want valid=1 out=%0d",
                         k, c, s, mod_valid, mod_out, expm(c, s));
            end
            if (k == 0 && chk_ready) begin
                vectors++;
                if (chip_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_pop: got %0d want 1", chip_ready);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, 40, 1);
        cyc(0, 0, -40, 0);
        rst = 1'b0;
        vectors++;
        if (mod_valid !== 1'b0 || mod_out !== 8'sd0 || chip_ready !== 1'b1 ||
            underflow !== 1'b0 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got valid=%0d out=%0d ready=%0d uf=%0d serr=%0d, want 0 0 1 0 0",
                     mod_valid, mod_out, chip_ready, underflow, sync_err);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, samp(k % 16), (k % 16) == 0);
            vectors++;
            if (mod_valid !== 1'b0 || mod_out !== 8'sd0 || underflow !== 1'b0 || chip_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_no_chips[%0d]: got valid=%0d out=%0d uf=%0d ready=%0d, want 0 0 0 1",
                         k, mod_valid, mod_out, underflow, chip_ready);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 0, 5, 0);
        cyc(1, 1, 5, 0);
        run_chip(0, 100, 37, 0);
        run_chip(1, 100, -55, 0);
        vectors++;
        if (sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_no_sync_err: got %0d want 0", sync_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(1, 1, 0, 0);
        run_chip(1, -128, 127, 0);
    endtask

    task automatic test_fifo_full();
        logic [4:0] chips;
        chips = 5'b01101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (chip_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %0d want 1", i, chip_ready);
            end
            cyc(1, chips[i], 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (chip_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL full_ready[%0d]: got %0d want 0", i, chip_ready);
            end
            if (i < 2) cyc(1, chips[4], 0, 0);
        end
        run_chip(1, 100, 20, 1);
        run_chip(0, 100, 20, 0);
        run_chip(1, 100, 20, 0);
        run_chip(1, 100, 20, 0);
        cyc(0, 0, 60, 1);
        vectors++;
        if (underflow !== 1'b1 || mod_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_no_fifth_chip: got uf=%0d valid=%0d want 1 0", underflow, mod_valid);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1, 0, 0, 0);
        run_chip(0, 100, -90, 0);
        cyc(0, 0, 60, 1);
        vectors++;
        if (underflow !== 1'b1 || mod_valid !== 1'b0 || mod_out !== 8'sd0) begin
            miscompares++;
            $display("FAIL underflow_pulse: got uf=%0d valid=%0d out=%0d want 1 0 0",
                     underflow, mod_valid, mod_out);
        end
        cyc(0, 0, 20, 0);
        vectors++;
        if (underflow !== 1'b0 || mod_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_one_cycle: got uf=%0d valid=%0d want 0 0", underflow, mod_valid);
        end
        // A chip that arrives together with sine_sync at an empty FIFO waits for the next sync.
        cyc(1, 1, 60, 1);
        vectors++;
        if (mod_valid !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL simultaneous_push_sync: got valid=%0d uf=%0d want 0 0", mod_valid, underflow);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0);
            vectors++;
            if (mod_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_wait[%0d]: got valid=%0d want 0", k, mod_valid);
            end
        end
        run_chip(1, 100, 45, 0);
    endtask

    task automatic test_sync_err_and_reset();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, samp(k), k == 0);
            vectors++;
            if (mod_valid !== 1'b1 || mod_out !== 8'(samp(k)) || sync_err !== 1'b0) begin
                miscompares++;
                $display("FAIL pre_err[%0d]: got valid=%0d out=%0d serr=%0d want 1 %0d 0",
                         k, mod_valid, mod_out, sync_err, samp(k));
            end
        end
        cyc(0, 0, 33, 1);
        vectors++;
        if (sync_err !== 1'b1 || mod_valid !== 1'b1 || mod_out !== -8'sd33) begin
            miscompares++;
            $display("FAIL sync_err_realign: got serr=%0d valid=%0d out=%0d want 1 1 -33",
                     sync_err, mod_valid, mod_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, (i < 2) ? 1'b1 : 1'b0, 40, 0);
            vectors++;
            if (sync_err !== 1'b1 || mod_out !== -8'sd40) begin
                miscompares++;
                $display("FAIL sync_err_sticky[%0d]: got serr=%0d out=%0d want 1 -40", i, sync_err, mod_out);
            end
        end
        rst = 1'b1;
        cyc(0, 0, 77, 0);
        rst = 1'b0;
        vectors++;
        if (mod_valid !== 1'b0 || mod_out !== 8'sd0 || sync_err !== 1'b0 ||
            underflow !== 1'b0 || chip_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%0d out=%0d serr=%0d uf=%0d ready=%0d want 0 0 0 0 1",
                     mod_valid, mod_out, sync_err, underflow, chip_ready);
        end
        cyc(0, 0, 77, 1);
        vectors++;
        if (mod_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_flushed: got valid=%0d want 0", mod_valid);
        end
    endtask

    initial begin
        rst        = 1'b1;
        chip_in    = 1'b0;
        chip_valid = 1'b0;
        sine_in    = '0;
        sine_sync  = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_fifo_full();
        test_underflow();
        test_sync_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
